// File: rtl/uart_rx_deframer_if.sv
// Receive holding-register interface between uart_rx_deframer and the APB slave.
// master = deframer side, slave = APB side.
interface uart_rx_deframer_if #(
    parameter int unsigned BITWIDTH = 8
);
    logic [BITWIDTH-1:0] DATA_OUT;
    logic                RX_RDY;
    logic                OVERFLOW;
    logic                FRAMING_ERR;
    logic                PARITY_ERR;
    logic                RD_ACK;
    logic                ERR_CLR;

    modport master (
        output DATA_OUT, RX_RDY, OVERFLOW, FRAMING_ERR, PARITY_ERR,
        input  RD_ACK, ERR_CLR
    );

    modport slave (
        input  DATA_OUT, RX_RDY, OVERFLOW, FRAMING_ERR, PARITY_ERR,
        output RD_ACK, ERR_CLR
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/[parity]/stop recovery into a holding register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_deframer #(
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETN,
    input  logic                    BAUD_TICK,
    input  logic                    RX,
    input  logic                    ODD_EVEN,
    uart_rx_deframer_if.master      rbuf
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(BITWIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BITWIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t              state;
    logic                rx_q1, rx_s;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [BITWIDTH-1:0] shreg;
    logic [BITWIDTH-1:0] data_out;
    logic                rx_rdy, overflow, framing_err, parity_err;
    logic                commit, par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = ((^shreg) ^ par_bit) != ODD_EVEN;
`else
    logic unused_odd_even;
    assign unused_odd_even = ODD_EVEN;
    assign par_bad         = 1'b0;
`endif

    always_comb begin
        commit = 1'b0;
        if (state == STOP && BAUD_TICK && cnt == CNT_LAST)
            commit = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= IDLE;
            rx_q1       <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data_out    <= '0;
            rx_rdy      <= 1'b0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            rx_q1 <= RX;
            rx_s  <= rx_q1;

            case (state)
                IDLE: if (BAUD_TICK && !rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (BAUD_TICK) begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: if (BAUD_TICK) begin
                    if (cnt == CNT_LAST) begin
                        shreg <= {rx_s, shreg[BITWIDTH-1:1]};
                        cnt   <= '0;
                        idx   <= idx + IW'(1);
                        if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (BAUD_TICK) begin
                    if (cnt == CNT_LAST) begin
                        par_bit <= rx_s;
                        cnt     <= '0;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: if (BAUD_TICK) begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A held-low line must go high before another start bit is accepted.
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Clear first so a same-cycle error set takes priority.
            if (rbuf.ERR_CLR) begin
                overflow    <= 1'b0;
                framing_err <= 1'b0;
                parity_err  <= 1'b0;
            end

            if (commit) begin
                if (!rx_rdy || rbuf.RD_ACK) begin
                    data_out <= shreg;
                    rx_rdy   <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
                if (!rx_s)   framing_err <= 1'b1;
                if (par_bad) parity_err  <= 1'b1;
            end else if (rbuf.RD_ACK) begin
                rx_rdy <= 1'b0;
            end
        end
    end

    assign rbuf.DATA_OUT    = data_out;
    assign rbuf.RX_RDY      = rx_rdy;
    assign rbuf.OVERFLOW    = overflow;
    assign rbuf.FRAMING_ERR = framing_err;
    assign rbuf.PARITY_ERR  = parity_err;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer: BAUD_TICK every 4 PCLK, 64 PCLK per bit.
module tb_uart_rx_deframer;
    logic PCLK = 1'b0;
    logic PRESETN;
    logic BAUD_TICK;
    logic RX;
    logic ODD_EVEN;
    logic [1:0] tcnt;

    int checks = 0;
    int errors = 0;

    uart_rx_deframer_if #(.BITWIDTH(8)) rbuf ();

    uart_rx_deframer #(.BITWIDTH(8), .OVERSAMPLE(16)) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .BAUD_TICK (BAUD_TICK),
        .RX        (RX),
        .ODD_EVEN  (ODD_EVEN),
        .rbuf      (rbuf.master)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) tcnt <= 2'd0;
        else          tcnt <= tcnt + 2'd1;
    assign BAUD_TICK = (tcnt == 2'd3);

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v);
        RX = v;
        repeat (64) @(negedge PCLK);
    endtask

    // Frame body; line is left at the stop-bit level.
    task automatic send_raw(input logic [7:0] d, input logic stop, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par !== 1'bx) RX = RX;
`endif
        drive_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_raw(d, stop, (^d) ^ ODD_EVEN);
    endtask

    task automatic pulse_ack;
        @(negedge PCLK) rbuf.RD_ACK = 1'b1;
        @(negedge PCLK) rbuf.RD_ACK = 1'b0;
    endtask

    task automatic pulse_clr;
        @(negedge PCLK) rbuf.ERR_CLR = 1'b1;
        @(negedge PCLK) rbuf.ERR_CLR = 1'b0;
    endtask

    task automatic test_reset;
        PRESETN = 1'b0; RX = 1'b1; ODD_EVEN = 1'b0;
        rbuf.RD_ACK = 1'b0; rbuf.ERR_CLR = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++;
        if ({rbuf.DATA_OUT, rbuf.RX_RDY, rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: actual=%h required=000",
                     {rbuf.DATA_OUT, rbuf.RX_RDY, rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR});
        end
        PRESETN = 1'b1;
        repeat (64) @(negedge PCLK);
    endtask

    task automatic test_basic_frame;
        send_frame(8'hA5, 1'b1);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.DATA_OUT !== 8'hA5) begin
            errors++; $display("FAIL basic_data: actual=%h required=a5", rbuf.DATA_OUT);
        end
        checks++;
        if (rbuf.RX_RDY !== 1'b1) begin
            errors++; $display("FAIL basic_rdy: actual=%b required=1", rbuf.RX_RDY);
        end
        pulse_ack;
        checks++;
        if (rbuf.RX_RDY !== 1'b0) begin
            errors++; $display("FAIL basic_ack: actual=%b required=0", rbuf.RX_RDY);
        end
        checks++;
        if ({rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR} !== 3'b000) begin
            errors++; $display("FAIL basic_flags: actual=%b required=000",
                               {rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR});
        end
        pulse_ack;
        checks++;
        if (rbuf.RX_RDY !== 1'b0 || rbuf.DATA_OUT !== 8'hA5) begin
            errors++; $display("FAIL idle_ack: actual=%b/%h required=0/a5", rbuf.RX_RDY, rbuf.DATA_OUT);
        end
    endtask

    task automatic test_glitch;
        RX = 1'b0;
        repeat (12) @(negedge PCLK);
        RX = 1'b1;
        repeat (20 * 64) @(negedge PCLK);
        checks++;
        if ({rbuf.RX_RDY, rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR} !== 4'b0000) begin
            errors++; $display("FAIL glitch_reject: actual=%b required=0000",
                               {rbuf.RX_RDY, rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR});
        end
    endtask

    task automatic test_framing_break;
        send_frame(8'h3C, 1'b0);
        repeat (40 * 64) @(negedge PCLK);
        checks++;
        if (rbuf.FRAMING_ERR !== 1'b1) begin
            errors++; $display("FAIL framing_flag: actual=%b required=1", rbuf.FRAMING_ERR);
        end
        checks++;
        if (rbuf.DATA_OUT !== 8'h3C || rbuf.RX_RDY !== 1'b1) begin
            errors++; $display("FAIL framing_data: actual=%h/%b required=3c/1", rbuf.DATA_OUT, rbuf.RX_RDY);
        end
        checks++;
        if (rbuf.OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL break_single_commit: actual=%b required=0", rbuf.OVERFLOW);
        end
        drive_bit(1'b1);
        pulse_ack;
        send_frame(8'h11, 1'b1);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.DATA_OUT !== 8'h11 || rbuf.RX_RDY !== 1'b1 || rbuf.OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL after_break: actual=%h/%b/%b required=11/1/0",
                               rbuf.DATA_OUT, rbuf.RX_RDY, rbuf.OVERFLOW);
        end
        pulse_clr;
        checks++;
        if (rbuf.FRAMING_ERR !== 1'b0) begin
            errors++; $display("FAIL framing_clr: actual=%b required=0", rbuf.FRAMING_ERR);
        end
        pulse_ack;
    endtask

    task automatic test_overflow;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL overflow_flag: actual=%b required=1", rbuf.OVERFLOW);
        end
        checks++;
        if (rbuf.DATA_OUT !== 8'h01 || rbuf.RX_RDY !== 1'b1) begin
            errors++; $display("FAIL overflow_keep: actual=%h/%b required=01/1", rbuf.DATA_OUT, rbuf.RX_RDY);
        end
        pulse_clr;
        checks++;
        if (rbuf.OVERFLOW !== 1'b0 || rbuf.RX_RDY !== 1'b1) begin
            errors++; $display("FAIL overflow_clr: actual=%b/%b required=0/1", rbuf.OVERFLOW, rbuf.RX_RDY);
        end
        pulse_ack;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        ODD_EVEN = 1'b1;
        send_raw(8'h07, 1'b1, 1'b0);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.PARITY_ERR !== 1'b0 || rbuf.DATA_OUT !== 8'h07) begin
            errors++; $display("FAIL parity_odd_ok: actual=%b/%h required=0/07", rbuf.PARITY_ERR, rbuf.DATA_OUT);
        end
        pulse_ack;
        send_raw(8'h07, 1'b1, 1'b1);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.PARITY_ERR !== 1'b1 || rbuf.DATA_OUT !== 8'h07) begin
            errors++; $display("FAIL parity_odd_bad: actual=%b/%h required=1/07", rbuf.PARITY_ERR, rbuf.DATA_OUT);
        end
        pulse_clr;
        pulse_ack;
        ODD_EVEN = 1'b0;
        send_raw(8'h07, 1'b1, 1'b1);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.PARITY_ERR !== 1'b0) begin
            errors++; $display("FAIL parity_even_ok: actual=%b required=0", rbuf.PARITY_ERR);
        end
        pulse_ack;
    endtask
`endif

    task automatic test_reset_midframe;
        send_frame(8'h66, 1'b1);
        repeat (32) @(negedge PCLK);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX = 1'b1;
        repeat (32) @(negedge PCLK);
        PRESETN = 1'b0;
        repeat (2) @(negedge PCLK);
        checks++;
        if (rbuf.RX_RDY !== 1'b0 || rbuf.DATA_OUT !== 8'h00) begin
            errors++; $display("FAIL midframe_reset: actual=%b/%h required=0/00", rbuf.RX_RDY, rbuf.DATA_OUT);
        end
        PRESETN = 1'b1;
        repeat (3 * 64) @(negedge PCLK);
        send_frame(8'h5A, 1'b1);
        repeat (32) @(negedge PCLK);
        checks++;
        if (rbuf.DATA_OUT !== 8'h5A || rbuf.RX_RDY !== 1'b1) begin
            errors++; $display("FAIL after_reset_data: actual=%h/%b required=5a/1", rbuf.DATA_OUT, rbuf.RX_RDY);
        end
        checks++;
        if ({rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR} !== 3'b000) begin
            errors++; $display("FAIL after_reset_flags: actual=%b required=000",
                               {rbuf.OVERFLOW, rbuf.FRAMING_ERR, rbuf.PARITY_ERR});
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_glitch;
        test_framing_break;
        test_overflow;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_reset_midframe;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
